// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall/bubble, branch flush and LM/SM beat sequencer for the 6-stage pipeline.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_hazard_ctrl #(
  parameter logic [3:0] OPC_LM = 4'b0110,
  parameter logic [3:0] OPC_SM = 4'b0111,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid_id,
  input  logic [3:0]       opcode_id,
  input  logic [7:0]       imm8_id,
  input  logic [2:0]       ra_rr,
  input  logic [2:0]       rb_rr,
  input  logic             uses_ra_rr,
  input  logic             uses_rb_rr,
  input  logic             ld_ex,
  input  logic             w_reg_ex,
  input  logic [2:0]       rd_ex,
  input  logic             branch_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_rr,
  output logic             flush_id_rr,
  output logic [1:0]       lm_start,
  output logic [2:0]       lm_reg,
  output logic [2:0]       lm_offset,
`ifdef HAZARD_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [7:0] mask, mask_n;
  logic [2:0] beat, beat_n, low;
  logic first, first_n, rst_q, en, hz, entry, multi, stall;
  // outputs are held quiet during reset and for the cycle right after it
  assign en = ~rst & ~rst_q;
  assign hz = ld_ex & w_reg_ex & ((uses_ra_rr & (ra_rr == rd_ex)) | (uses_rb_rr & (rb_rr == rd_ex)));
  assign entry = instr_valid_id & ((opcode_id == OPC_LM) | (opcode_id == OPC_SM)) & (|imm8_id);
  assign multi = |(mask & (mask - 8'd1));
  assign stall_if = stall;
  assign stall_id = stall;
  assign busy = en & (state == RUN);
  always_comb begin
    low = 3'd0;
    for (int i = 7; i >= 0; i--) if (mask[i]) low = 3'(i);
  end
  always_comb begin
    state_n = state;
    mask_n = mask;
    beat_n = beat;
    first_n = first;
    stall = 1'b0;
    bubble_rr = 1'b0;
    flush_id_rr = 1'b0;
    lm_start = 2'b00;
    lm_reg = 3'd0;
    lm_offset = 3'd0;
    if (!en) begin
      state_n = state;
    end else if (branch_taken_ex) begin
      flush_id_rr = 1'b1;
      state_n = IDLE;
      mask_n = 8'd0;
    end else if (state == IDLE) begin
      stall = hz | entry;
      bubble_rr = hz;
      if (entry & ~hz) begin
        state_n = RUN;
        mask_n = imm8_id;
        beat_n = 3'd0;
        first_n = 1'b1;
      end
    end else begin
      stall = hz | multi;
      bubble_rr = hz;
      lm_start = {1'b1, first};
      lm_reg = low;
      lm_offset = beat;
      if (!hz) begin
        mask_n = mask & (mask - 8'd1);
        beat_n = beat + 3'd1;
        first_n = 1'b0;
        state_n = multi ? RUN : IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state <= IDLE;
      mask <= 8'd0;
      beat <= 3'd0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      beat <= beat_n;
      first <= first_n;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed LM/SM sequences and random traffic against a queue-based model.
module tb_pipe_hazard_ctrl;
  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;
  logic clk = 1'b0;
  logic rst, instr_valid_id, uses_ra_rr, uses_rb_rr, ld_ex, w_reg_ex, branch_taken_ex;
  logic [3:0] opcode_id;
  logic [7:0] imm8_id;
  logic [2:0] ra_rr, rb_rr, rd_ex;
  logic stall_if, stall_id, bubble_rr, flush_id_rr, busy;
  logic [1:0] lm_start;
  logic [2:0] lm_reg, lm_offset;
`ifdef HAZARD_STALL_CNT_EN
  logic [3:0] stall_cnt;
`endif
  pipe_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid_id(instr_valid_id), .opcode_id(opcode_id), .imm8_id(imm8_id),
    .ra_rr(ra_rr), .rb_rr(rb_rr), .uses_ra_rr(uses_ra_rr), .uses_rb_rr(uses_rb_rr),
    .ld_ex(ld_ex), .w_reg_ex(w_reg_ex), .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_rr(bubble_rr), .flush_id_rr(flush_id_rr),
    .lm_start(lm_start), .lm_reg(lm_reg), .lm_offset(lm_offset),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int q[$];
  int m_beat = 0, e_reg, e_off;
  bit m_first = 0, m_run = 0, m_rst_q = 1, m_en, m_hz, m_ent;
  bit e_stall, e_bub, e_flush, e_busy;
  logic [1:0] e_start;
  typedef struct {
    logic ld, wr;
    logic [2:0] rd, ra, rb;
    logic ua, ub, br, x_stall, x_bub, x_flush;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_eval();
    m_en = !rst && !m_rst_q;
    m_hz = ld_ex && w_reg_ex && ((uses_ra_rr && ra_rr == rd_ex) || (uses_rb_rr && rb_rr == rd_ex));
    m_ent = instr_valid_id && (opcode_id == LM || opcode_id == SM) && imm8_id != 0;
    {e_stall, e_bub, e_flush, e_busy} = 4'b0;
    e_start = 2'b00;
    e_reg = 0;
    e_off = 0;
    if (m_en) begin
      e_busy = m_run;
      if (branch_taken_ex) e_flush = 1;
      else if (!m_run) begin
        e_stall = m_hz || m_ent;
        e_bub = m_hz;
      end else begin
        e_stall = m_hz || q.size() > 1;
        e_bub = m_hz;
        e_start = m_first ? 2'b11 : 2'b10;
        e_reg = q[0];
        e_off = m_beat;
      end
    end
  endtask
  task automatic model_next();
    if (rst) begin
      q.delete();
      m_run = 0;
    end else if (m_en) begin
      if (branch_taken_ex) begin
        q.delete();
        m_run = 0;
      end else if (!m_run) begin
        if (m_ent && !m_hz) begin
          q.delete();
          for (int i = 0; i < 8; i++) if (imm8_id[i]) q.push_back(i);
          m_beat = 0;
          m_first = 1;
          m_run = 1;
        end
      end else if (!m_hz) begin
        void'(q.pop_front());
        m_beat++;
        m_first = 0;
        if (q.size() == 0) m_run = 0;
      end
    end
    m_rst_q = rst;
  endtask
  task automatic cyc();
    #1;
    model_eval();
    chk("stall_if", stall_if, e_stall);
    chk("stall_id", stall_id, e_stall);
    chk("bubble_rr", bubble_rr, e_bub);
    chk("flush_id_rr", flush_id_rr, e_flush);
    chk("lm_start", lm_start, e_start);
    if (!branch_taken_ex) chk("busy", busy, e_busy);
    if (e_start != 2'b00) begin
      chk("lm_reg", lm_reg, e_reg);
      chk("lm_offset", lm_offset, e_off);
    end
    model_next();
    @(negedge clk);
  endtask
  task automatic idle_in();
    {instr_valid_id, uses_ra_rr, uses_rb_rr, ld_ex, w_reg_ex, branch_taken_ex} = 6'b0;
    opcode_id = 4'd0;
    imm8_id = 8'd0;
    {ra_rr, rb_rr, rd_ex} = 9'd0;
  endtask
  task automatic set_hz(input bit on);
    ld_ex = on;
    w_reg_ex = on;
    uses_ra_rr = on;
    rd_ex = 3'd1;
    ra_rr = 3'd1;
  endtask
  task automatic enter(input logic [3:0] opc, input logic [7:0] imm);
    instr_valid_id = 1;
    opcode_id = opc;
    imm8_id = imm;
  endtask
  initial begin
    int nb, last_off, nbub;
    tbl[0] = '{1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 1, 1, 0};
    tbl[1] = '{1, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 3'd5, 3'd0, 3'd5, 1, 1, 0, 1, 1, 0};
    tbl[3] = '{0, 1, 3'd3, 3'd3, 3'd3, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 3'd3, 3'd3, 3'd3, 1, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 1, 3'd2, 3'd3, 3'd4, 1, 1, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 3'd7, 3'd7, 3'd0, 1, 0, 1, 0, 0, 1};
    tbl[7] = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 1};
    tbl[8] = '{1, 1, 3'd0, 3'd5, 3'd0, 1, 1, 0, 1, 1, 0};
    idle_in();
    rst = 1;
    cyc();
    #1 chk("rst_busy", busy, 0);
    cyc();
    rst = 0;
    set_hz(1);
    enter(LM, 8'hFF);
    #1 chk("post_rst_stall", stall_if, 0);
    chk("post_rst_bubble", bubble_rr, 0);
    cyc();
    idle_in();
    cyc();
    for (int i = 0; i < 9; i++) begin
      ld_ex = tbl[i].ld;
      w_reg_ex = tbl[i].wr;
      rd_ex = tbl[i].rd;
      ra_rr = tbl[i].ra;
      rb_rr = tbl[i].rb;
      uses_ra_rr = tbl[i].ua;
      uses_rb_rr = tbl[i].ub;
      branch_taken_ex = tbl[i].br;
      #1 chk($sformatf("vec%0d_stall", i), stall_if, tbl[i].x_stall);
      chk($sformatf("vec%0d_bubble", i), bubble_rr, tbl[i].x_bub);
      chk($sformatf("vec%0d_flush", i), flush_id_rr, tbl[i].x_flush);
      cyc();
    end
    idle_in();
    cyc();
    begin
      int st[4] = '{3, 2, 2, 0};
      int rg[3] = '{2, 5, 7};
      int sl[4] = '{1, 1, 0, 0};
      int bz[4] = '{1, 1, 1, 0};
      enter(LM, 8'b1010_0100);
      #1 chk("lm_entry_stall", stall_if, 1);
      chk("lm_entry_start", lm_start, 0);
      cyc();
      idle_in();
      for (int i = 0; i < 4; i++) begin
        #1 chk($sformatf("lm%0d_start", i), lm_start, st[i]);
        if (i < 3) begin
          chk($sformatf("lm%0d_reg", i), lm_reg, rg[i]);
          chk($sformatf("lm%0d_off", i), lm_offset, i);
        end
        chk($sformatf("lm%0d_stall", i), stall_if, sl[i]);
        chk($sformatf("lm%0d_busy", i), busy, bz[i]);
        cyc();
      end
    end
    enter(SM, 8'h00);
    #1 chk("sm0_stall", stall_if, 0);
    chk("sm0_start", lm_start, 0);
    cyc();
    idle_in();
    #1 chk("sm0_busy", busy, 0);
    cyc();
    enter(LM, 8'h01);
    set_hz(1);
    #1 chk("blk_stall", stall_if, 1);
    chk("blk_bubble", bubble_rr, 1);
    chk("blk_start", lm_start, 0);
    cyc();
    set_hz(0);
    #1 chk("retry_stall", stall_if, 1);
    cyc();
    idle_in();
    #1 chk("retry_start", lm_start, 3);
    chk("retry_stall_last", stall_if, 0);
    cyc();
    cyc();
    nb = 0;
    last_off = -1;
    nbub = 0;
    enter(LM, 8'hFF);
    cyc();
    idle_in();
    for (int i = 0; i < 12; i++) begin
      set_hz(i == 3);
      #1;
      if (lm_start != 2'b00) begin
        nb++;
        last_off = lm_offset;
      end
      if (bubble_rr) nbub++;
      if (i == 4) chk("ff_repeat_reg", lm_reg, 3);
      cyc();
    end
    chk("ff_beats", nb, 9);
    chk("ff_last_off", last_off, 7);
    chk("ff_bubbles", nbub, 1);
    idle_in();
    enter(LM, 8'h0F);
    cyc();
    idle_in();
    cyc();
    branch_taken_ex = 1;
    #1 chk("br_flush", flush_id_rr, 1);
    chk("br_stall", stall_if, 0);
    chk("br_bubble", bubble_rr, 0);
    chk("br_start", lm_start, 0);
    cyc();
    branch_taken_ex = 0;
    #1 chk("br_busy_after", busy, 0);
    chk("br_start_after", lm_start, 0);
    cyc();
    enter(LM, 8'hFF);
    cyc();
    idle_in();
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    #1 chk("rstrun_busy", busy, 0);
    chk("rstrun_start", lm_start, 0);
    chk("rstrun_stall", stall_if, 0);
    cyc();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      branch_taken_ex = ($urandom_range(0, 15) == 0);
      instr_valid_id = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: opcode_id = LM;
        1: opcode_id = SM;
        default: opcode_id = 4'($urandom);
      endcase
      imm8_id = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ld_ex = ($urandom_range(0, 3) == 0);
      w_reg_ex = $urandom_range(0, 1);
      rd_ex = 3'($urandom);
      ra_rr = $urandom_range(0, 1) ? rd_ex : 3'($urandom);
      rb_rr = 3'($urandom);
      uses_ra_rr = $urandom_range(0, 1);
      uses_rb_rr = $urandom_range(0, 1);
      cyc();
    end
    idle_in();
    rst = 1;
    cyc();
    rst = 0;
    cyc();
`ifdef HAZARD_STALL_CNT_EN
    #1 chk("cnt_clear", stall_cnt, 0);
    set_hz(1);
    cyc();
    for (int i = 0; i < 9; i++) cyc();
    #1 chk("cnt_10", stall_cnt, 10);
    for (int i = 0; i < 10; i++) cyc();
    #1 chk("cnt_sat", stall_cnt, 15);
    set_hz(0);
    rst = 1;
    cyc();
    rst = 0;
    #1 chk("cnt_rst", stall_cnt, 0);
    cyc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall, flush and LM/SM beat sequencer for the 6-stage IITB-RISC pipeline. It detects load-use hazards that forwarding cannot cover and holds IF/ID while inserting a bubble into EX. It also unrolls LM/SM into one beat per selected register and drives the `lm_start` code consumed by the data-forwarding unit. It sits beside the forwarding unit and observes ID, RR and EX stage fields.

## Interface
- `OPC_LM`, default 4'b0110: LM opcode.
- `OPC_SM`, default 4'b0111: SM opcode.
- `CNT_W`, default 16: stall counter width (used only with `HAZARD_STALL_CNT_EN`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `instr_valid_id` in 1: ID holds a valid instruction.
- `opcode_id` in 4: ID opcode.
- `imm8_id` in 8: ID LM/SM register list.
- `ra_rr`, `rb_rr` in 3: RR source register indices.
- `uses_ra_rr`, `uses_rb_rr` in 1: RR instruction actually reads RA/RB.
- `ld_ex` in 1: EX instruction is a load (LW or LM beat).
- `w_reg_ex` in 1: EX instruction writes the register file.
- `rd_ex` in 3: EX destination register.
- `branch_taken_ex` in 1: EX resolved a redirect.
- `stall_if`, `stall_id` out 1: hold PC / IF-ID register.
- `bubble_rr` out 1: replace the RR→EX payload with a NOP.
- `flush_id_rr` out 1: invalidate ID and RR.
- `lm_start` out 2: 00 idle, 11 first beat, 10 later beat.
- `lm_reg` out 3: register index of the current beat.
- `lm_offset` out 3: beat number (word offset from base).
- `busy` out 1: FSM is in RUN.
- `stall_cnt` out CNT_W: present only with `HAZARD_STALL_CNT_EN`.

## Operation
- `hz` = `ld_ex & w_reg_ex & ((uses_ra_rr & ra_rr==rd_ex) | (uses_rb_rr & rb_rr==rd_ex))`. `hz` is combinational.
- Priority: `rst` > `branch_taken_ex` > `hz` > LM/SM entry/advance.
- FSM states: IDLE and RUN. Registered state: 8-bit `mask`, 3-bit `beat`, `first` flag.
- **IDLE → RUN**: `instr_valid_id`, opcode ∈ {LM, SM}, `imm8_id != 0`, no flush, no `hz`. Action: `mask <= imm8_id`, `beat <= 0`, `first <= 1`.
- **`imm8_id == 0`**: no sequencing. The instruction passes as a NOP and `lm_start` stays 00.
- **RUN, each cycle without `hz`**:
  - `lm_reg` = index of the lowest set bit of `mask`. `lm_offset` = `beat`. `lm_start` = {1, `first`}.
  - Next state: clear that bit, `beat` +1, `first <= 0`.
  - When the popcount of `mask` is 1, the cycle is the last beat and the FSM returns to IDLE.
- **RUN with `hz`**: `mask`, `beat` and `first` hold. The beat outputs repeat next cycle. `bubble_rr` = 1.
- **Stall outputs**:
  - `stall_if` = `stall_id` = `hz` | (IDLE entry condition) | (RUN & popcount(`mask`) > 1).
  - `bubble_rr` = `hz` only.
- **`branch_taken_ex`**: in any state, `flush_id_rr` = 1 and the FSM goes to IDLE with `mask` = 0. Stall and bubble outputs are 0 that cycle.
- `beat` never wraps: at most 8 beats, values 0..7.

## Timing
- All outputs are 0 during reset and in the first cycle after reset.
- `hz`-derived outputs are same-cycle combinational. Load-use costs exactly 1 bubble per hazard.
- LM/SM with k set bits, decoded in ID at cycle N:
  - `stall_if`/`stall_id` are high for cycles N..N+k-1.
  - Beats appear on cycles N+1..N+k (`lm_start` 11, then 10…).
  - `busy` is high for N+1..N+k.
  - Each `hz` cycle adds 1 to the sequence length.
- Entry blocked by `hz` at cycle N is retried at N+1; the ID instruction is held.
- A flush in the last-beat cycle wins: no beat is reported, and the state is IDLE next cycle.
- A reset asserted mid-RUN takes effect at the next edge: IDLE, all outputs 0.

## Configuration
- `HAZARD_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` port.
  - Increments by 1 on every cycle with `stall_if` = 1.
  - Saturates at 2^CNT_W−1.
  - Cleared by `rst` only.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- LW r3 in EX (`ld_ex`=1, `rd_ex`=3), RR reads `ra_rr`=3 with `uses_ra_rr`=1 → `stall_if`=`stall_id`=`bubble_rr`=1 for exactly 1 cycle. Same with `uses_ra_rr`=0 → no stall.
- LM with `imm8_id`=8'b1010_0100 → 3 beats: `lm_reg` 2,5,7; `lm_offset` 0,1,2; `lm_start` 11,10,10. Stall is high for 2 cycles then drops; `busy` is high for 3 cycles.
- SM with `imm8_id`=8'h00 → no beats, no stall, `lm_start` stays 00.
- LM `imm8_id`=8'hFF with `hz` forced on beat 3 → beat 3 (`lm_reg`=3) is repeated, `bubble_rr`=1 for 1 cycle, 9 beat cycles in total, last `lm_offset`=7.
- `branch_taken_ex`=1 during beat 2 of 4 → `flush_id_rr`=1, all stalls 0, IDLE next cycle. `rst` mid-RUN → all outputs 0 next cycle.
- With `HAZARD_STALL_CNT_EN` and CNT_W=4: 20 stall cycles → `stall_cnt`=15. Then `rst` → 0.
